// File: rtl/delay_arb_pkg.sv
// Shared types and helpers for the delay arbiter: FSM state encoding,
// ID width helper and round-robin index / one-hot functions.
package delay_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Widest requester vector the one-hot helper can produce.
  localparam int MAX_REQ = 32;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Next index in round-robin order, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  function automatic logic [MAX_REQ-1:0] to_onehot(input int unsigned idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request strictly after the
// pointer, wrapping around; the pointer itself is considered last.
module rr_arbiter
  import delay_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    pointer,
  output logic [NUM_REQ-1:0] winner_oh,
  output logic [ID_W-1:0]    winner_idx,
  output logic               valid
);

  always_comb begin
    int unsigned idx;
    // NOTE: every output gets a default before the search so no path through
    // this block leaves a value unassigned, which would infer a latch.
    winner_oh  = '0;
    winner_idx = '0;
    valid      = 1'b0;
    idx        = int'(pointer);
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = rr_next(idx, NUM_REQ);
      if (!valid && req[ID_W'(idx)]) begin
        valid      = 1'b1;
        winner_idx = ID_W'(idx);
        winner_oh  = NUM_REQ'(to_onehot(idx));
      end
    end
  end

endmodule

// File: rtl/delay_arbiter.sv
// One programmable delay counter shared round-robin among NUM_REQ requesters.
// Optional `pause` input when DELAY_ARB_PAUSE_EN is defined.
module delay_arbiter
  import delay_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int CNT_BITS = 8,
  localparam int ID_W     = id_width(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef DELAY_ARB_PAUSE_EN
  input  logic                         pause,
`endif
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*CNT_BITS-1:0]  req_len,
  output logic [NUM_REQ-1:0]           grant,
  output logic [ID_W-1:0]              active_id,
  output logic [CNT_BITS-1:0]          count,
  output logic                         busy,
  output logic [NUM_REQ-1:0]           done
);

  state_t              state;
  logic [ID_W-1:0]     ptr;
  logic [CNT_BITS-1:0] len_q;

  logic [NUM_REQ-1:0]  win_oh;
  logic [ID_W-1:0]     win_idx;
  logic                win_valid;
  logic [CNT_BITS-1:0] win_len;
  logic                hold;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req        (req),
    .pointer    (ptr),
    .winner_oh  (win_oh),
    .winner_idx (win_idx),
    .valid      (win_valid)
  );

  assign win_len = req_len[win_idx*CNT_BITS +: CNT_BITS];

`ifdef DELAY_ARB_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= ID_W'(NUM_REQ - 1);
      len_q     <= '0;
      grant     <= '0;
      active_id <= '0;
      count     <= '0;
      busy      <= 1'b0;
      done      <= '0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            len_q     <= win_len;
            grant     <= win_oh;
            active_id <= win_idx;
            count     <= '0;
            busy      <= 1'b1;
            ptr       <= win_idx;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Abort has priority over both pause and completion.
          if (!req[active_id]) begin
            grant     <= '0;
            active_id <= '0;
            count     <= '0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else if (hold) begin
            count <= count;
          end else if (count == len_q) begin
            done      <= grant;
            grant     <= '0;
            active_id <= '0;
            count     <= '0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
